// File: rtl/id_exe_skid_reg_pkg.sv
// Shared types for the ID/EXE skid pipeline register.
package id_exe_pkg;

  localparam int unsigned IMM_W      = 16;
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned ALU_CTRL_W = 4;

  // Decoded control fields carried alongside the operands.
  typedef struct packed {
    logic [IMM_W-1:0]      imm;
    logic                  sel_mux_alu;
    logic [REG_ADDR_W-1:0] dest;
    logic                  wb;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  mem_wr;
    logic                  mem_rd;
  } id_exe_ctrl_t;

  localparam int unsigned CTRL_W = $bits(id_exe_ctrl_t);

  // Occupancy of the main + skid storage.
  typedef enum logic [1:0] {
    LVL_EMPTY = 2'd0,
    LVL_ONE   = 2'd1,
    LVL_TWO   = 2'd2
  } lvl_e;

endpackage

// File: rtl/id_exe_skid_reg_if.sv
// ID-side and EXE-side handshake bundle of the ID/EXE skid register.
interface id_exe_skid_reg_if
  import id_exe_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned LANES       = 1,
  parameter int unsigned STALL_CNT_W = 16
);
  localparam int unsigned OP_W = LANES * DATA_W;

  logic                   in_valid;
  logic                   in_ready;
  logic [IMM_W-1:0]       in_imm;
  logic                   in_sel_mux_alu;
  logic [REG_ADDR_W-1:0]  in_dest;
  logic                   in_wb;
  logic [ALU_CTRL_W-1:0]  in_alu_ctrl;
  logic                   in_mem_wr;
  logic                   in_mem_rd;
  logic [OP_W-1:0]        in_op_a;
  logic [OP_W-1:0]        in_op_b;

  logic                   out_valid;
  logic                   out_ready;
  logic [IMM_W-1:0]       out_imm;
  logic                   out_sel_mux_alu;
  logic [REG_ADDR_W-1:0]  out_dest;
  logic                   out_wb;
  logic [ALU_CTRL_W-1:0]  out_alu_ctrl;
  logic                   out_mem_wr;
  logic                   out_mem_rd;
  logic [OP_W-1:0]        out_op_a;
  logic [OP_W-1:0]        out_op_b;

  logic [1:0]             level;
  logic [STALL_CNT_W-1:0] stall_cnt;

  // Surrounding pipeline: drives ID beats and EXE ready.
  modport master (
    output in_valid, in_imm, in_sel_mux_alu, in_dest, in_wb, in_alu_ctrl,
           in_mem_wr, in_mem_rd, in_op_a, in_op_b, out_ready,
    input  in_ready, out_valid, out_imm, out_sel_mux_alu, out_dest, out_wb,
           out_alu_ctrl, out_mem_wr, out_mem_rd, out_op_a, out_op_b,
           level, stall_cnt
  );

  // The pipeline register itself.
  modport slave (
    input  in_valid, in_imm, in_sel_mux_alu, in_dest, in_wb, in_alu_ctrl,
           in_mem_wr, in_mem_rd, in_op_a, in_op_b, out_ready,
    output in_ready, out_valid, out_imm, out_sel_mux_alu, out_dest, out_wb,
           out_alu_ctrl, out_mem_wr, out_mem_rd, out_op_a, out_op_b,
           level, stall_cnt
  );

endinterface

// File: rtl/id_exe_skid_reg_field_reg.sv
// Enable-loaded storage register, cleared by async active-low reset.
module id_exe_field_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load on enable, otherwise hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_exe_skid_reg.sv
// ID/EXE pipeline register with 2-entry skid buffer, flush and stall counter.
module id_exe_skid_reg
  import id_exe_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned LANES       = 1,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  id_exe_skid_reg_if.slave bus
);

  localparam int unsigned OP_W  = LANES * DATA_W;
  localparam int unsigned PAY_W = CTRL_W + 2 * OP_W;

  typedef struct packed {
    id_exe_ctrl_t    ctrl;
    logic [OP_W-1:0] op_a;
    logic [OP_W-1:0] op_b;
  } beat_t;

  lvl_e                   level_q, level_d;
  logic                   main_valid_q, main_valid_d;
  logic                   skid_valid_q, skid_valid_d;
  logic                   in_ready_q, in_ready_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   main_en, skid_en, main_from_skid;
  logic                   accept_c, pop_c;
  beat_t                  in_beat, main_d, main_q, skid_q;

  assign in_beat.ctrl.imm         = bus.in_imm;
  assign in_beat.ctrl.sel_mux_alu = bus.in_sel_mux_alu;
  assign in_beat.ctrl.dest        = bus.in_dest;
  assign in_beat.ctrl.wb          = bus.in_wb;
  assign in_beat.ctrl.alu_ctrl    = bus.in_alu_ctrl;
  assign in_beat.ctrl.mem_wr      = bus.in_mem_wr;
  assign in_beat.ctrl.mem_rd      = bus.in_mem_rd;
  assign in_beat.op_a             = bus.in_op_a;
  assign in_beat.op_b             = bus.in_op_b;

  assign accept_c = bus.in_valid & in_ready_q;
  assign pop_c    = main_valid_q & bus.out_ready;
  assign main_d   = main_from_skid ? skid_q : in_beat;

  // Control state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level_q      <= LVL_EMPTY;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      stall_q      <= '0;
    end else begin
      level_q      <= level_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      stall_q      <= stall_d;
    end
  end

  // Occupancy transitions, storage load enables and stall counting.
  always_comb begin
    level_d        = level_q;
    main_valid_d   = main_valid_q;
    skid_valid_d   = skid_valid_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    stall_d        = stall_q;

    unique case (level_q)
      LVL_EMPTY: begin
        if (accept_c) begin
          main_en      = 1'b1;
          main_valid_d = 1'b1;
          level_d      = LVL_ONE;
        end
      end
      LVL_ONE: begin
        if (accept_c && pop_c) begin
          main_en = 1'b1;
        end else if (accept_c) begin
          skid_en      = 1'b1;
          skid_valid_d = 1'b1;
          level_d      = LVL_TWO;
        end else if (pop_c) begin
          main_valid_d = 1'b0;
          level_d      = LVL_EMPTY;
        end
      end
      LVL_TWO: begin
        if (pop_c) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          skid_valid_d   = 1'b0;
          level_d        = LVL_ONE;
        end
      end
      default: begin
        level_d      = LVL_EMPTY;
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end
    endcase

    // Flush wins over accept and pop; stale data may stay in storage.
    if (flush) begin
      main_en      = 1'b0;
      skid_en      = 1'b0;
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      level_d      = LVL_EMPTY;
    end

    in_ready_d = !skid_valid_d;

    if (main_valid_q && !bus.out_ready && (stall_q != '1)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  id_exe_field_reg #(.W(PAY_W)) u_main (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (main_en),
    .d       (main_d),
    .q       (main_q)
  );

  id_exe_field_reg #(.W(PAY_W)) u_skid (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (skid_en),
    .d       (in_beat),
    .q       (skid_q)
  );

  assign bus.in_ready        = in_ready_q;
  assign bus.out_valid       = main_valid_q;
  assign bus.out_imm         = main_q.ctrl.imm;
  assign bus.out_sel_mux_alu = main_q.ctrl.sel_mux_alu;
  assign bus.out_dest        = main_q.ctrl.dest;
  assign bus.out_wb          = main_q.ctrl.wb & main_valid_q;
  assign bus.out_alu_ctrl    = main_q.ctrl.alu_ctrl;
  assign bus.out_mem_wr      = main_q.ctrl.mem_wr & main_valid_q;
  assign bus.out_mem_rd      = main_q.ctrl.mem_rd & main_valid_q;
  assign bus.out_op_a        = main_q.op_a;
  assign bus.out_op_b        = main_q.op_b;
  assign bus.level           = 2'(level_q);
  assign bus.stall_cnt       = stall_q;

endmodule

// File: tb/tb_id_exe_skid_reg.sv
// Scoreboard bench for the ID/EXE skid register.
module tb_id_exe_skid_reg;
  import id_exe_pkg::*;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned LANES       = 1;
  localparam int unsigned STALL_CNT_W = 4;
  localparam int          STALL_MAX   = (1 << STALL_CNT_W) - 1;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic flush   = 1'b0;

  always #5 clock = ~clock;

  id_exe_skid_reg_if #(.DATA_W(DATA_W), .LANES(LANES), .STALL_CNT_W(STALL_CNT_W)) bus ();

  id_exe_skid_reg #(.DATA_W(DATA_W), .LANES(LANES), .STALL_CNT_W(STALL_CNT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  typedef struct {
    logic [15:0] imm;
    logic        sel;
    logic [3:0]  dest;
    logic        wb;
    logic [3:0]  alu;
    logic        mw;
    logic        mr;
    logic [15:0] a;
    logic [15:0] b;
  } beat_t;

  beat_t q[$];
  int    total        = 0;
  int    bad          = 0;
  int    exp_stall    = 0;
  bit    mon_en       = 1'b0;
  bit    mdl_in_ready = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t zero_beat();
    beat_t b;
    b.imm = '0; b.sel = 1'b0; b.dest = '0; b.wb = 1'b0; b.alu = '0;
    b.mw = 1'b0; b.mr = 1'b0; b.a = '0; b.b = '0;
    return b;
  endfunction

  function automatic beat_t rnd_beat();
    beat_t b;
    b.imm  = 16'($urandom);
    b.sel  = 1'($urandom);
    b.dest = 4'($urandom);
    b.wb   = 1'($urandom);
    b.alu  = 4'($urandom);
    b.mw   = 1'($urandom);
    b.mr   = 1'($urandom);
    b.a    = 16'($urandom);
    b.b    = 16'($urandom);
    return b;
  endfunction

  // Drive one cycle of stimulus; record what the model says gets accepted.
  task automatic cycle(input bit v, input beat_t b, input bit ordy, input bit fl);
    @(negedge clock);
    bus.in_valid       = v;
    bus.in_imm         = b.imm;
    bus.in_sel_mux_alu = b.sel;
    bus.in_dest        = b.dest;
    bus.in_wb          = b.wb;
    bus.in_alu_ctrl    = b.alu;
    bus.in_mem_wr      = b.mw;
    bus.in_mem_rd      = b.mr;
    bus.in_op_a        = b.a;
    bus.in_op_b        = b.b;
    bus.out_ready      = ordy;
    flush              = fl;
    #4;
    if (fl) q.delete();
    else if (v && mdl_in_ready) q.push_back(b);
  endtask

  // Monitor: occupancy/stall invariants and in-order pop comparison.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (mon_en) begin : mon
        int occ;
        beat_t e;
        occ = q.size();
        chk("level", 64'(bus.level), 64'(occ));
        chk("out_valid", 64'(bus.out_valid), 64'(occ != 0));
        chk("in_ready", 64'(bus.in_ready), 64'(occ < 2));
        chk("stall_cnt", 64'(bus.stall_cnt), 64'(exp_stall));
        if (occ == 0) begin
          chk("gate_wb", 64'(bus.out_wb), 64'(0));
          chk("gate_mem_wr", 64'(bus.out_mem_wr), 64'(0));
          chk("gate_mem_rd", 64'(bus.out_mem_rd), 64'(0));
        end
        mdl_in_ready = (occ < 2);
        if (occ != 0 && bus.out_ready && !flush) begin
          e = q.pop_front();
          chk("out_imm", 64'(bus.out_imm), 64'(e.imm));
          chk("out_sel_mux_alu", 64'(bus.out_sel_mux_alu), 64'(e.sel));
          chk("out_dest", 64'(bus.out_dest), 64'(e.dest));
          chk("out_wb", 64'(bus.out_wb), 64'(e.wb));
          chk("out_alu_ctrl", 64'(bus.out_alu_ctrl), 64'(e.alu));
          chk("out_mem_wr", 64'(bus.out_mem_wr), 64'(e.mw));
          chk("out_mem_rd", 64'(bus.out_mem_rd), 64'(e.mr));
          chk("out_op_a", 64'(bus.out_op_a), 64'(e.a));
          chk("out_op_b", 64'(bus.out_op_b), 64'(e.b));
        end
        if (occ != 0 && !bus.out_ready && exp_stall < STALL_MAX) exp_stall++;
      end
    end
  end

  initial begin : main
    beat_t b;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_imm = '0; bus.in_sel_mux_alu = 1'b0; bus.in_dest = '0; bus.in_wb = 1'b0;
    bus.in_alu_ctrl = '0; bus.in_mem_wr = 1'b0; bus.in_mem_rd = 1'b0;
    bus.in_op_a = '0; bus.in_op_b = '0;

    // Reset state.
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_level", 64'(bus.level), 64'(0));
    chk("rst_stall", 64'(bus.stall_cnt), 64'(0));
    chk("rst_op_a", 64'(bus.out_op_a), 64'(0));
    chk("rst_imm", 64'(bus.out_imm), 64'(0));
    chk("rst_dest", 64'(bus.out_dest), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // First beat latency.
    b = zero_beat(); b.a = 16'h1234; b.dest = 4'h5; b.wb = 1'b1;
    cycle(1'b1, b, 1'b1, 1'b0);
    cycle(1'b0, zero_beat(), 1'b1, 1'b0);

    // Back-to-back streaming.
    for (int i = 1; i <= 4; i++) begin
      b = zero_beat(); b.a = 16'(i);
      cycle(1'b1, b, 1'b1, 1'b0);
    end
    cycle(1'b0, zero_beat(), 1'b1, 1'b0);
    cycle(1'b0, zero_beat(), 1'b1, 1'b0);

    // Fill under back-pressure, then drain in order.
    b = zero_beat(); b.a = 16'h000A; cycle(1'b1, b, 1'b0, 1'b0);
    b = zero_beat(); b.a = 16'h000B; cycle(1'b1, b, 1'b0, 1'b0);
    b = zero_beat(); b.a = 16'h000C; cycle(1'b1, b, 1'b0, 1'b0);
    cycle(1'b0, zero_beat(), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, zero_beat(), 1'b1, 1'b0);

    // Flush from full, with a same-cycle accept attempt.
    b = rnd_beat(); b.mw = 1'b1; b.wb = 1'b1; b.mr = 1'b1; cycle(1'b1, b, 1'b0, 1'b0);
    b = rnd_beat(); b.mw = 1'b1; cycle(1'b1, b, 1'b0, 1'b0);
    cycle(1'b0, zero_beat(), 1'b0, 1'b0);
    b = rnd_beat(); cycle(1'b1, b, 1'b0, 1'b1);
    cycle(1'b0, zero_beat(), 1'b1, 1'b0);
    cycle(1'b0, zero_beat(), 1'b1, 1'b0);

    // Stall counter saturation.
    b = rnd_beat(); cycle(1'b1, b, 1'b0, 1'b0);
    for (int i = 0; i < (1 << STALL_CNT_W) + 3; i++) cycle(1'b0, zero_beat(), 1'b0, 1'b0);
    chk("stall_saturated", 64'(bus.stall_cnt), 64'(STALL_MAX));
    cycle(1'b0, zero_beat(), 1'b1, 1'b0);
    cycle(1'b0, zero_beat(), 1'b1, 1'b0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), rnd_beat(), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 31) == 0));
    end

    // Asynchronous reset between edges.
    cycle(1'b1, rnd_beat(), 1'b0, 1'b0);
    cycle(1'b1, rnd_beat(), 1'b0, 1'b0);
    @(posedge clock);
    #2;
    mon_en = 1'b0;
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(bus.out_valid), 64'(0));
    chk("async_level", 64'(bus.level), 64'(0));
    chk("async_stall", 64'(bus.stall_cnt), 64'(0));
    chk("async_gate_wb", 64'(bus.out_wb), 64'(0));
    q.delete();
    exp_stall = 0;
    mdl_in_ready = 1'b1;
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    b = rnd_beat();
    cycle(1'b1, b, 1'b1, 1'b0);
    cycle(1'b0, zero_beat(), 1'b1, 1'b0);
    cycle(1'b0, zero_beat(), 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
